if_fetch_stage: RTL

Instruction-fetch stage sitting directly upstream of the instruction memory: owns the program counter, drives the combinational IMEM read address, and captures each returned word with its PC into a small FIFO presented to decode through a valid/ready handshake. Handles control-flow redirects (flush and refetch) and raises a sticky fault on misaligned or out-of-range fetch addresses.

---
 rtl/if_pkg.sv | 25 ++
 rtl/if_fetch_stage_fifo.sv | 60 ++++++
 rtl/if_fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch slice: fetch entry payload,
// FSM encoding and the address legality helper used by the fetch stage.
package if_pkg;

  localparam int unsigned INSTR_W        = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEF_IMEM_BYTES = 4096;
  localparam int unsigned DEF_DEPTH      = 2;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t ST_RUN   = 1'b0;
  localparam fetch_state_t ST_FAULT = 1'b1;

  // A fetch address is legal when word aligned and inside the IMEM window.
  function automatic logic fetch_addr_legal(input logic [31:0] pc,
                                            input int unsigned imem_bytes);
    return (pc[1:0] == 2'b00) && (pc < 32'(imem_bytes));
  endfunction

endpackage

// File: rtl/if_fetch_stage_fifo.sv
// Synchronous fetch FIFO (power-of-two depth) carrying {pc, instr} entries to decode.
// A flush empties it and overrides any push or pop issued in the same cycle.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage carries only data; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives IMEM combinationally, queues fetched
// words for decode, handles redirects and raises a sticky fault on illegal PCs.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned IMEM_BYTES = DEF_IMEM_BYTES
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               fault,
  output logic [31:0]        fault_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pc_q,       pc_d;
  fetch_state_t     state_q,    state_d;
  logic             fault_q,    fault_d;
  logic [31:0]      fault_pc_q, fault_pc_d;

  logic             push;
  logic             pop;
  logic             push_ok;
  logic             pc_legal;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_din;
  fetch_entry_t     fifo_head;

  assign imem_addr = pc_q;
  assign pc_legal  = fetch_addr_legal(pc_q, IMEM_BYTES);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign push_ok   = (fifo_count < CNT_W'(DEPTH)) || (fifo_full && pop);

  assign fifo_din.pc    = pc_q;
  assign fifo_din.instr = imem_instr;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head fields read as zero when nothing is queued.
  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? '0 : fifo_head.pc;
  assign out_instr = fifo_empty ? '0 : fifo_head.instr;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

  // Redirect outranks everything; otherwise RUN either faults, fetches or stalls.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = ST_RUN;
      fault_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (!pc_legal) begin
        fault_d    = 1'b1;
        fault_pc_d = pc_q;
        state_d    = ST_FAULT;
      end else if (push_ok) begin
        push = 1'b1;
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_RUN;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

endmodule
